// File: rtl/pcomp_dma_arbiter_if.sv
// Purpose: bundles the requester-side and engine-side signals of the pcomp DMA arbiter.
// Latency: none, wiring only.
// Backpressure: none here; the engine paces transfers with ack/done/valid.
interface pcomp_dma_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*32-1:0] req_addr_i;
    logic [NUM_REQ*8-1:0]  req_len_i;
    logic [NUM_REQ-1:0]    req_ack_o;
    logic [NUM_REQ-1:0]    req_done_o;
    logic [NUM_REQ-1:0]    req_valid_o;
    logic [31:0]           req_data_o;
    logic                  dma_req_o;
    logic                  dma_ack_i;
    logic                  dma_done_i;
    logic [31:0]           dma_addr_o;
    logic [7:0]            dma_len_o;
    logic [31:0]           dma_data_i;
    logic                  dma_valid_i;
    logic [NUM_REQ-1:0]    grant_o;
    logic [31:0]           STATUS;

    // Arbiter side
    modport slave (
        input  req_i, req_addr_i, req_len_i,
        input  dma_ack_i, dma_done_i, dma_data_i, dma_valid_i,
        output req_ack_o, req_done_o, req_valid_o, req_data_o,
        output dma_req_o, dma_addr_o, dma_len_o, grant_o, STATUS
    );

    // Requesters plus engine side
    modport master (
        output req_i, req_addr_i, req_len_i,
        output dma_ack_i, dma_done_i, dma_data_i, dma_valid_i,
        input  req_ack_o, req_done_o, req_valid_o, req_data_o,
        input  dma_req_o, dma_addr_o, dma_len_o, grant_o, STATUS
    );
endinterface

// File: rtl/pcomp_dma_arbiter.sv
// Purpose: round-robin share of one DMA read engine among NUM_REQ pcomp tables.
// Latency: request to dma_req_o one cycle; ack/done/valid steered combinationally.
// Backpressure: engine paces everything; requesters hold req until acked.
module pcomp_dma_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    pcomp_dma_arbiter_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      r_last;
    logic [31:0]        r_addr;
    logic [7:0]         r_len;
    logic               r_dma_req;
    logic [8:0]         r_beats;
    logic [7:0]         r_last_beats;
    logic               r_len_mis;
    logic               r_stray_done;
    logic               r_stray_valid;

    logic               w_sel_vld;
    logic [IW-1:0]      w_sel_idx;
    logic [8:0]         w_beats_nxt;
    logic [8:0]         w_exp_beats;
    logic [NUM_REQ-1:0] w_ack;
    logic [NUM_REQ-1:0] w_done;
    logic [NUM_REQ-1:0] w_valid;

    // Round-robin pick: first set request bit above the last owner, wrapping
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_sel_vld && bus.req_i[(int'(r_last) + i) % NUM_REQ]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IW'((int'(r_last) + i) % NUM_REQ);
            end
        end
    end

    // Beat count including the current strobe, saturating; length 0 encodes 256
    always_comb begin
        w_beats_nxt = r_beats;
        if (bus.dma_valid_i && (r_beats != 9'd511)) begin
            w_beats_nxt = r_beats + 9'd1;
        end
        w_exp_beats = (r_len == 8'd0) ? 9'd256 : {1'b0, r_len};
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: ack wins over a coincident done in REQ
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_sel_vld)      w_state_nxt = S_REQ;
            S_REQ:  if (bus.dma_ack_i)  w_state_nxt = S_XFER;
            S_XFER: if (bus.dma_done_i) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Combinational steering of engine handshakes to the current owner only
    always_comb begin
        w_ack   = '0;
        w_done  = '0;
        w_valid = '0;
        if (r_state == S_REQ && bus.dma_ack_i) begin
            w_ack = r_grant;
        end
        if (r_state == S_XFER) begin
            if (bus.dma_done_i)  w_done  = r_grant;
            if (bus.dma_valid_i) w_valid = r_grant;
        end
    end

    // Grant/latch, beat counting and sticky protocol-error flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_grant       <= '0;
            r_gidx        <= '0;
            r_last        <= IW'(NUM_REQ - 1);
            r_addr        <= '0;
            r_len         <= '0;
            r_dma_req     <= 1'b0;
            r_beats       <= '0;
            r_last_beats  <= '0;
            r_len_mis     <= 1'b0;
            r_stray_done  <= 1'b0;
            r_stray_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld) begin
                        r_grant   <= NUM_REQ'(1) << w_sel_idx;
                        r_gidx    <= w_sel_idx;
                        r_addr    <= bus.req_addr_i[32*w_sel_idx +: 32];
                        r_len     <= bus.req_len_i[8*w_sel_idx +: 8];
                        r_dma_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.dma_ack_i) begin
                        r_dma_req <= 1'b0;
                        r_beats   <= '0;
                    end
                end
                S_XFER: begin
                    r_beats <= w_beats_nxt;
                    if (bus.dma_done_i) begin
                        r_last_beats <= w_beats_nxt[7:0];
                        if (w_beats_nxt != w_exp_beats) begin
                            r_len_mis <= 1'b1;
                        end
                        r_last  <= r_gidx;
                        r_grant <= '0;
                    end
                end
                default: ;
            endcase
            if (bus.dma_done_i && r_state != S_XFER) begin
                r_stray_done <= 1'b1;
            end
            if (bus.dma_valid_i && r_state != S_XFER) begin
                r_stray_valid <= 1'b1;
            end
        end
    end

    assign bus.req_ack_o   = w_ack;
    assign bus.req_done_o  = w_done;
    assign bus.req_valid_o = w_valid;
    assign bus.req_data_o  = bus.dma_data_i;
    assign bus.dma_req_o   = r_dma_req;
    assign bus.dma_addr_o  = r_addr;
    assign bus.dma_len_o   = r_len;
    assign bus.grant_o     = r_grant;
    assign bus.STATUS      = {16'd0, r_last_beats, 5'd0, r_stray_valid, r_stray_done, r_len_mis};
endmodule

// File: tb/tb_pcomp_dma_arbiter.sv
// Purpose: directed bench for pcomp_dma_arbiter with a burst table plus corner sequences.
// Latency: inputs driven 1ns after posedge, outputs checked 1-2ns after posedge.
// Backpressure: bench plays the DMA engine and paces ack/valid/done itself.
module tb_pcomp_dma_arbiter;
    logic clk_i;
    logic reset_i;
    int   checks;
    int   errors;

    pcomp_dma_arbiter_if #(.NUM_REQ(4)) bus ();

    pcomp_dma_arbiter #(.NUM_REQ(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  req;
        int          owner;
        logic [31:0] addr;
        logic [7:0]  len;
        int          ack_dly;
        int          nbeats;
        int          lat;     // cycles from bench's start point to dma_req_o
        logic [31:0] status;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Requester k sits at 0x1000 + k*0x100; all requesters share one length
    task automatic set_req(input logic [3:0] r, input logic [7:0] len);
        bus.req_i = r;
        for (int k = 0; k < 4; k++) begin
            bus.req_addr_i[32*k +: 32] = 32'h1000 + 32'(k) * 32'h100;
            bus.req_len_i[8*k +: 8]    = len;
        end
    endtask

    // Leaves the bench one cycle after the done edge, arbiter back in IDLE
    task automatic run_burst(input vec_t v);
        int         n;
        int         good;
        logic [3:0] oh;
        logic [31:0] d;
        oh = 4'b0001 << v.owner;
        set_req(v.req, v.len);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.dma_req_o === 1'b1) break;
        end
        chk("req_latency", 32'(n), 32'(v.lat));
        chk("grant", {28'd0, bus.grant_o}, {28'd0, oh});
        chk("dma_addr", bus.dma_addr_o, v.addr);
        chk("dma_len", {24'd0, bus.dma_len_o}, {24'd0, v.len});
        repeat (v.ack_dly) step();
        chk("req_hold", {31'd0, bus.dma_req_o}, 32'd1);
        bus.dma_ack_i = 1'b1;
        #1;
        chk("ack_pulse", {28'd0, bus.req_ack_o}, {28'd0, oh});
        step();
        bus.dma_ack_i = 1'b0;
        #1;
        chk("req_drop", {31'd0, bus.dma_req_o}, 32'd0);
        good = 0;
        for (int i = 0; i < v.nbeats; i++) begin
            d = {v.addr[15:0], 16'(i)};
            bus.dma_valid_i = 1'b1;
            bus.dma_data_i  = d;
            #1;
            if (bus.req_valid_o === oh && bus.req_data_o === d) good++;
            step();
            bus.dma_valid_i = 1'b0;
        end
        chk("beats_steered", 32'(good), 32'(v.nbeats));
        bus.dma_done_i = 1'b1;
        #1;
        chk("done_pulse", {28'd0, bus.req_done_o}, {28'd0, oh});
        step();
        bus.dma_done_i = 1'b0;
        #1;
        chk("status", bus.STATUS, v.status);
        chk("grant_idle", {28'd0, bus.grant_o}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_i = 1'b1;
        bus.req_i = '0;
        bus.req_addr_i = '0;
        bus.req_len_i = '0;
        bus.dma_ack_i = 1'b0;
        bus.dma_done_i = 1'b0;
        bus.dma_data_i = '0;
        bus.dma_valid_i = 1'b0;

        //        req     own addr        len   ack beats lat status
        tbl[0] = '{4'b0001, 0, 32'h1000, 8'd4, 3, 4,   1, 32'h0000_0400};
        // Held 1111: owners rotate; lat 1 here plus the done edge = 2 cycles after done
        tbl[1] = '{4'b1111, 1, 32'h1100, 8'd1, 0, 1,   1, 32'h0000_0100};
        tbl[2] = '{4'b1111, 2, 32'h1200, 8'd1, 1, 1,   1, 32'h0000_0100};
        tbl[3] = '{4'b1111, 3, 32'h1300, 8'd1, 0, 1,   1, 32'h0000_0100};
        tbl[4] = '{4'b1111, 0, 32'h1000, 8'd1, 2, 1,   1, 32'h0000_0100};
        tbl[5] = '{4'b1111, 1, 32'h1100, 8'd1, 0, 1,   1, 32'h0000_0100};
        // len 0 means 256; 255 delivered is a mismatch
        tbl[6] = '{4'b0100, 2, 32'h1200, 8'd0, 1, 255, 1, 32'h0000_FF01};
        // correct burst keeps the sticky mismatch bit
        tbl[7] = '{4'b1000, 3, 32'h1300, 8'd2, 0, 2,   1, 32'h0000_0201};

        step();
        step();
        chk("rst_grant", {28'd0, bus.grant_o}, 32'd0);
        chk("rst_dma_req", {31'd0, bus.dma_req_o}, 32'd0);
        chk("rst_status", bus.STATUS, 32'd0);
        chk("rst_addr", bus.dma_addr_o, 32'd0);
        reset_i = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_burst(tbl[t]);
        end

        // Reset in the middle of a burst to requester 0, requester 2 still waiting
        set_req(4'b0001, 8'd8);
        step();
        chk("rx_grant0", {28'd0, bus.grant_o}, 32'h1);
        step();
        bus.dma_ack_i = 1'b1;
        step();
        bus.dma_ack_i = 1'b0;
        repeat (2) begin
            bus.dma_valid_i = 1'b1;
            step();
            bus.dma_valid_i = 1'b0;
        end
        set_req(4'b0100, 8'd8);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("rx_grant_cleared", {28'd0, bus.grant_o}, 32'd0);
        chk("rx_dma_req_cleared", {31'd0, bus.dma_req_o}, 32'd0);
        chk("rx_addr_cleared", bus.dma_addr_o, 32'd0);
        chk("rx_len_cleared", {24'd0, bus.dma_len_o}, 32'd0);
        chk("rx_status_cleared", bus.STATUS, 32'd0);
        chk("rx_no_pulses", {20'd0, bus.req_ack_o, bus.req_done_o, bus.req_valid_o}, 32'd0);
        step();
        chk("rx_regrant2", {28'd0, bus.grant_o}, 32'h4);
        chk("rx_relatch_addr", bus.dma_addr_o, 32'h1200);
        chk("rx_dma_req", {31'd0, bus.dma_req_o}, 32'd1);

        // Ack and done together in REQ: ack taken, done is stray
        bus.dma_ack_i = 1'b1;
        bus.dma_done_i = 1'b1;
        #1;
        chk("ad_ack", {28'd0, bus.req_ack_o}, 32'h4);
        chk("ad_no_done", {28'd0, bus.req_done_o}, 32'd0);
        step();
        bus.dma_ack_i = 1'b0;
        bus.dma_done_i = 1'b0;
        bus.req_i = '0;
        #1;
        chk("ad_dma_req_drop", {31'd0, bus.dma_req_o}, 32'd0);
        chk("ad_stray_done", bus.STATUS, 32'h0000_0002);
        bus.dma_valid_i = 1'b1;
        #1;
        chk("ad_in_xfer", {28'd0, bus.req_valid_o}, 32'h4);
        step();
        bus.dma_valid_i = 1'b0;
        bus.dma_done_i = 1'b1;
        #1;
        chk("ad_done", {28'd0, bus.req_done_o}, 32'h4);
        step();
        bus.dma_done_i = 1'b0;
        #1;
        chk("ad_status", bus.STATUS, 32'h0000_0103);

        // Stray done and valid while IDLE
        bus.dma_valid_i = 1'b1;
        bus.dma_done_i = 1'b1;
        #1;
        chk("st_no_valid", {28'd0, bus.req_valid_o}, 32'd0);
        chk("st_no_done", {28'd0, bus.req_done_o}, 32'd0);
        step();
        bus.dma_valid_i = 1'b0;
        bus.dma_done_i = 1'b0;
        #1;
        chk("st_status", bus.STATUS, 32'h0000_0107);
        chk("st_idle_grant", {28'd0, bus.grant_o}, 32'd0);
        chk("st_idle_req", {31'd0, bus.dma_req_o}, 32'd0);
        run_burst('{4'b1000, 3, 32'h1300, 8'd1, 0, 1, 1, 32'h0000_0107});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
